// File: rtl/calc_inv_pkg.sv
// Shared types and default widths for the calc_inv bitwise-inverter engine.
package calc_inv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam int DEF_DATA_W  = 128;
    localparam int DEF_CHUNK_W = 32;

endpackage

// File: rtl/calc_inv.sv
// Multi-cycle one's-complement engine: inverts a captured word CHUNK_W bits per clock.
// Latency: capture edge K, done high after edge K+NUM_CHUNKS.
// Flow: requester holds en and waits for done; en low for one edge re-arms the engine.
module calc_inv
    import calc_inv_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int CHUNK_W = DEF_CHUNK_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              done
);

    localparam int NUM_CHUNKS = (CHUNK_W > 0) ? DATA_W / CHUNK_W : 1;
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    generate
        if ((CHUNK_W <= 0) || ((DATA_W % CHUNK_W) != 0)) begin : g_bad_cfg
            $fatal(1, "calc_inv: DATA_W must be a positive multiple of CHUNK_W");
        end
    endgenerate

    state_t             state_q;
    state_t             next_state;
    logic [IDX_W-1:0]   idx_q;
    logic [DATA_W-1:0]  work_q;
    logic               last_chunk;

    assign last_chunk = (idx_q == IDX_W'(NUM_CHUNKS - 1));

    always_comb begin
        next_state = state_q;
        case (state_q)
            IDLE:    if (en)         next_state = BUSY;
            BUSY:    if (last_chunk) next_state = DONE;
            DONE:    if (!en)        next_state = IDLE;
            default:                 next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            work_q  <= '0;
            data_o  <= '0;
            done    <= 1'b0;
        end else begin
            state_q <= next_state;
            done    <= (next_state == DONE);
            case (state_q)
                IDLE: begin
                    if (en) begin
                        work_q <= data_i;
                        data_o <= '0;
                        idx_q  <= '0;
                    end
                end
                BUSY: begin
                    // Constant-offset chunk select keeps the write mux free of variable shifts.
                    for (int c = 0; c < NUM_CHUNKS; c++) begin
                        if (idx_q == IDX_W'(c)) begin
                            data_o[c*CHUNK_W +: CHUNK_W] <= ~work_q[c*CHUNK_W +: CHUNK_W];
                        end
                    end
                    idx_q <= idx_q + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_inv.sv
// Scoreboard bench for calc_inv: default 4-chunk instance plus a single-chunk instance.
module tb_calc_inv;

    typedef struct {
        logic [127:0] dat;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         en_b;
    logic [127:0] data_i;
    logic [127:0] data_i_b;
    logic [127:0] data_o;
    logic [127:0] data_o_b;
    logic         done;
    logic         done_b;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    logic done_prev_a = 1'b0;
    logic done_prev_b = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    calc_inv u_a (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .data_i (data_i),
        .data_o (data_o),
        .done   (done)
    );

    calc_inv #(.DATA_W(128), .CHUNK_W(128)) u_b (
        .clk    (clk),
        .rst    (rst),
        .en     (en_b),
        .data_i (data_i_b),
        .data_o (data_o_b),
        .done   (done_b)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitors: every rising done is matched against the oldest expected result.
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (!rst && done && !done_prev_a) begin
            if (q_a.size() == 0) begin
                chk("a_unexpected_done", 128'(done), 128'(0));
            end else begin
                e = q_a.pop_front();
                chk("a_result", data_o, e.dat);
                chk("a_latency", 128'(cyc), 128'(e.cyc));
            end
        end
        done_prev_a = done;
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (!rst && done_b && !done_prev_b) begin
            if (q_b.size() == 0) begin
                chk("b_unexpected_done", 128'(done_b), 128'(0));
            end else begin
                e = q_b.pop_front();
                chk("b_result", data_o_b, e.dat);
                chk("b_latency", 128'(cyc), 128'(e.cyc));
            end
        end
        done_prev_b = done_b;
    end

    task automatic wait_a(input string nm);
        int n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 128'(done), 128'(1));
    endtask

    task automatic wait_b(input string nm);
        int n = 0;
        while (!done_b && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 128'(done_b), 128'(1));
    endtask

    // One full operation on the 4-chunk instance, releasing en as soon as done is seen.
    task automatic run_a(input string nm, input logic [127:0] d, input logic [127:0] exp);
        @(negedge clk);
        data_i = d;
        en     = 1'b1;
        q_a.push_back('{dat: exp, cyc: cyc + 5});
        @(negedge clk);
        chk({nm, "_clr"}, data_o, 128'(0));
        wait_a({nm, "_wait"});
        en = 1'b0;
        @(negedge clk);
        chk({nm, "_idle"}, 128'(done), 128'(0));
        chk({nm, "_hold"}, data_o, exp);
    endtask

    task automatic run_b(input string nm, input logic [127:0] d, input logic [127:0] exp);
        @(negedge clk);
        data_i_b = d;
        en_b     = 1'b1;
        q_b.push_back('{dat: exp, cyc: cyc + 2});
        wait_b({nm, "_wait"});
        en_b = 1'b0;
        @(negedge clk);
        chk({nm, "_idle"}, 128'(done_b), 128'(0));
        chk({nm, "_hold"}, data_o_b, exp);
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        en_b     = 1'b0;
        data_i   = '0;
        data_i_b = '0;

        // Reset state, then release with en low.
        @(negedge clk);
        chk("rst_data", data_o, 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_data_b", data_o_b, 128'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_data", data_o, 128'(0));
        chk("post_rst_done", 128'(done), 128'(0));

        // Basic operation, en held through DONE.
        data_i = 128'hFFFFFFFFFFFFFFFF0000000000000000;
        en     = 1'b1;
        q_a.push_back('{dat: 128'h0000000000000000FFFFFFFFFFFFFFFF, cyc: cyc + 5});
        @(negedge clk);
        chk("basic_busy_done", 128'(done), 128'(0));
        wait_a("basic_wait");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("basic_hold_done", 128'(done), 128'(1));
            chk("basic_hold_data", data_o, 128'h0000000000000000FFFFFFFFFFFFFFFF);
        end
        en = 1'b0;
        @(negedge clk);
        chk("basic_release", 128'(done), 128'(0));

        // Operand stability: data_i cleared and en dropped while BUSY.
        data_i = {16{8'hA5}};
        en     = 1'b1;
        q_a.push_back('{dat: {16{8'h5A}}, cyc: cyc + 5});
        @(negedge clk);
        data_i = '0;
        @(negedge clk);
        en = 1'b0;
        wait_a("stab_wait");
        @(negedge clk);
        chk("stab_one_cycle", 128'(done), 128'(0));
        chk("stab_hold", data_o, {16{8'h5A}});

        // Back-to-back: previous result must clear on capture.
        data_i = 128'h0123456789ABCDEF0011223344556677;
        en     = 1'b1;
        q_a.push_back('{dat: 128'hFEDCBA9876543210FFEEDDCCBBAA9988, cyc: cyc + 5});
        @(negedge clk);
        chk("b2b_clr", data_o, 128'(0));
        wait_a("b2b_wait");
        @(negedge clk);
        chk("b2b_no_restart", 128'(done), 128'(1));
        en = 1'b0;
        @(negedge clk);
        chk("b2b_release", 128'(done), 128'(0));

        // Reset after two BUSY edges: asynchronous clear, no result.
        data_i = '0;
        en     = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_data", data_o, 128'(0));
        chk("midrst_done", 128'(done), 128'(0));
        en = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Edge operands on both instances.
        run_a("zeros_a", 128'(0), {128{1'b1}});
        run_a("ones_a", {128{1'b1}}, 128'(0));
        run_b("zeros_b", 128'(0), {128{1'b1}});
        run_b("ones_b", {128{1'b1}}, 128'(0));
        run_b("mix_b", 128'h0123456789ABCDEF0011223344556677,
              128'hFEDCBA9876543210FFEEDDCCBBAA9988);

        repeat (3) @(negedge clk);
        chk("sb_a_empty", 128'(q_a.size()), 128'(0));
        chk("sb_b_empty", 128'(q_b.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
